mul_div_unit: RTL and testbench

Iterative multiply/divide unit consuming the two register-file read operands in the execute stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per start pulse. It holds the architectural HI/LO registers and signals completion with a one-cycle done pulse. While busy is high, the pipeline controller must stall any instruction that reads HI/LO or starts another operation.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 50 +++++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, step count.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mdu_pkg;

  // op field encoding driven by the decode stage; 6 and 7 are no-ops
  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // one radix-2 iteration per cycle over a 32-bit operand
  localparam int STEPS = 32;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring shift-subtract divide step.
// Latency: combinational (0 cycles).
// Backpressure: none; evaluated every cycle, the caller decides when to register it.
//
// Ports:
//   mode_div  1     0 = multiply step, 1 = divide step
//   acc       2W    multiply: {partial product, remaining multiplier bits}
//                   divide:   {partial remainder, remaining dividend / quotient bits}
//   operand   W     multiplicand or divisor (magnitude)
//   acc_nxt   2W    accumulator after this step (divide: bit 0 left clear)
//   q_bit     1     quotient bit produced by a divide step (0 for multiply)
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic                 q_bit
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    acc_nxt = '0;
    q_bit   = 1'b0;

    // multiply: add the multiplicand when the current multiplier LSB is set,
    // keep the carry, then shift the whole 64-bit accumulator right by one
    addend = acc[0] ? operand : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // divide: bring the next dividend bit into the partial remainder; the
    // remainder is always below the divisor, so a 33-bit window cannot overflow
    // and the subtract's top bit is a clean borrow flag
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, operand};

    if (mode_div) begin
      q_bit   = ~diff[WIDTH];
      acc_nxt = {(q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers; also serves MTHI/MTLO.
// Latency: multiply/divide 34 cycles accept-to-result (done pulse with HI/LO); MTHI/MTLO 1 cycle.
// Backpressure: busy=1 while an operation is in flight; start is ignored (not sampled) while busy.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start, op       request and op code (see mdu_pkg), accepted only when busy=0
//   src_a, src_b    register-file read operands, sampled only on the accepting edge
//   busy            operation in flight
//   done            one-cycle pulse, hi/lo hold the new result during it
//   hi, lo          HI (product upper / remainder) and LO (product lower / quotient)
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     a_raw;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0;

  logic                 arith_op;
  logic                 op_div;
  logic                 op_signed;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 step_q;

  assign busy = (state != IDLE);

  // operand decode for the accepting edge
  always_comb begin
    arith_op  = op inside {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV};
    op_div    = (op == OP_DIVU) || (op == OP_DIV);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_nxt  (step_acc),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && arith_op) state_nxt = RUN;
      RUN:  if (cnt == CNT_W'(STEPS - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (arith_op) begin
              // multiply iterates over the multiplier held in acc's low half;
              // divide shifts the dividend out of acc's low half
              acc    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
              opnd   <= op_div ? mag_b : mag_a;
              a_raw  <= src_a;
              is_div <= op_div;
              neg_q  <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              neg_r  <= op_signed && src_a[WIDTH-1];
              div0   <= op_div && (src_b == '0);
              cnt    <= '0;
            end else if (op == OP_MTHI) begin
              hi <= src_a;
            end else if (op == OP_MTLO) begin
              lo <= src_a;
            end
          end
        end
        RUN: begin
          acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (!is_div) begin
            acc <= neg_q ? -acc : acc;
          end else if (div0) begin
            acc <= {a_raw, {WIDTH{1'b1}}};
          end else begin
            // 0x80000000 / -1 falls out naturally: magnitude quotient
            // 0x80000000 negates to itself, remainder is 0
            acc <= {(neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]),
                    (neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0])};
          end
        end
        DONE: begin
          hi   <= acc[2*WIDTH-1:WIDTH];
          lo   <= acc[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops against an arithmetic model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference result {hi, lo} computed from plain integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: p = {32'd0, a} * {32'd0, b};
      3'd1: p = 64'(sa * sb);
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else            p = {a % b, a / b};
      end
      default: begin
        if (b == 32'd0)                                     p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)  p = {32'd0, 32'h8000_0000};
        else                                                p = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7, 0))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  // Issue one arithmetic op and wait for its done pulse. Operand/op inputs
  // are scrambled while busy; if inj_k > 0 an MTLO 9 start is driven at E<inj_k>.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_k, output logic [31:0] rh, output logic [31:0] rl);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int lat;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick;  // E0
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_low_after_accept", 32'(done), 32'd0);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      src_a = $urandom;
      src_b = $urandom;
      op    = 3'($urandom);
      if (k == inj_k) begin
        start = 1'b1;
        op    = 3'd5;
        src_a = 32'd9;
      end
      tick;
      start = 1'b0;
      if (k == 33) begin
        chk("hi_hold_E33", hi, old_hi);
        chk("lo_hold_E33", lo, old_lo);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd34);
    chk("busy_low_with_done", 32'(busy), 32'd0);
    rh = hi;
    rl = lo;
  endtask

  initial begin
    logic [31:0] rh;
    logic [31:0] rl;
    logic [63:0] exp;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          dcount;

    rst = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    tick;
    tick;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // no-op codes must leave everything untouched
    start = 1'b1; op = 3'd6; src_a = 32'h1234_5678; src_b = 32'h9;
    tick;
    op = 3'd7;
    tick;
    start = 1'b0;
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_done", 32'(done), 32'd0);
    chk("noop_hi", hi, 32'd0);
    chk("noop_lo", lo, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 0, rh, rl);
    chk("mult_neg3x7_hi", rh, 32'hFFFF_FFFF);
    chk("mult_neg3x7_lo", rl, 32'hFFFF_FFEB);

    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, rh, rl);
    chk("multu_max_hi", rh, 32'hFFFF_FFFE);
    chk("multu_max_lo", rl, 32'd1);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, rh, rl);
    chk("div_neg7by2_hi", rh, 32'hFFFF_FFFF);
    chk("div_neg7by2_lo", rl, 32'hFFFF_FFFD);

    run_op(3'd2, 32'd100, 32'd7, 0, rh, rl);
    chk("divu_100by7_hi", rh, 32'd2);
    chk("divu_100by7_lo", rl, 32'd14);

    run_op(3'd2, 32'd5, 32'd0, 0, rh, rl);
    chk("divu_by0_hi", rh, 32'd5);
    chk("divu_by0_lo", rl, 32'hFFFF_FFFF);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, rh, rl);
    chk("div_ovf_hi", rh, 32'd0);
    chk("div_ovf_lo", rl, 32'h8000_0000);

    // MTLO 9 attempted at E10 must be ignored
    run_op(3'd1, 32'd2, 32'd3, 10, rh, rl);
    chk("overlap_hi", rh, 32'd0);
    chk("overlap_lo", rl, 32'd6);

    // issued in the done cycle, so accepted at E35
    run_op(3'd0, 32'd4, 32'd5, 0, rh, rl);
    chk("b2b_hi", rh, 32'd0);
    chk("b2b_lo", rl, 32'd20);
    tick;
    chk("done_pulse_end", 32'(done), 32'd0);

    // reset in the middle of a divide: nothing completes, HI/LO cleared
    start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    tick;  // E0
    start = 1'b0;
    repeat (14) tick;  // E1..E14
    rst = 1'b1;
    tick;  // E15
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
    tick;
    start = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_busy", 32'(busy), 32'd0);
    start = 1'b1; op = 3'd5; src_a = 32'h0000_CAFE;
    tick;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_CAFE);
    chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
    chk("mt_no_done", 32'(done), 32'd0);
    dcount = 0;
    repeat (40) begin
      tick;
      if (done) dcount++;
    end
    chk("no_done_after_reset", 32'(dcount), 32'd0);

    // random arithmetic ops against the model
    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(3, 0));
      ra  = pick();
      rb  = pick();
      exp = model(ro, ra, rb);
      run_op(ro, ra, rb, 0, rh, rl);
      chk($sformatf("rand%0d_op%0d_hi", i, ro), rh, exp[63:32]);
      chk($sformatf("rand%0d_op%0d_lo", i, ro), rl, exp[31:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
